// File: rtl/dm_host_arb.sv
// dm_host_arb: round-robin arbiter sharing one req/gnt/r_valid system-bus host
// port between NumReq masters. Granted transaction IDs are kept in order in a
// small FIFO so that each in-order response is routed back to its issuer.
module dm_host_arb #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_i,
  input  logic [NumReq-1:0]              we_i,
  input  logic [NumReq*BusWidth-1:0]     addr_i,
  input  logic [NumReq*BusWidth-1:0]     wdata_i,
  input  logic [NumReq*BusWidth/8-1:0]   be_i,
  output logic [NumReq-1:0]              gnt_o,
  output logic [NumReq-1:0]              r_valid_o,
  output logic [BusWidth-1:0]            r_rdata_o,
  output logic                           host_req_o,
  output logic                           host_we_o,
  output logic [BusWidth-1:0]            host_add_o,
  output logic [BusWidth-1:0]            host_wdata_o,
  output logic [BusWidth/8-1:0]          host_be_o,
  input  logic                           host_gnt_i,
  input  logic                           host_r_valid_i,
  input  logic [BusWidth-1:0]            host_r_rdata_i,
  output logic                           spurious_rsp_o
);

  localparam int unsigned IdW  = $clog2(NumReq);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeW  = BusWidth / 8;

  // Per-requester views of the flattened request buses
  logic [BusWidth-1:0] addr_arr  [NumReq];
  logic [BusWidth-1:0] wdata_arr [NumReq];
  logic [BeW-1:0]      be_arr    [NumReq];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_split
    assign addr_arr[gi]  = addr_i[gi*BusWidth +: BusWidth];
    assign wdata_arr[gi] = wdata_i[gi*BusWidth +: BusWidth];
    assign be_arr[gi]    = be_i[gi*BeW +: BeW];
  end

  // Arbitration state
  logic [IdW-1:0]  prio_q, prio_d;
  logic            lock_q, lock_d;
  logic [IdW-1:0]  lock_id_q, lock_id_d;

  // ID FIFO state
  logic [IdW-1:0]  id_mem_q [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            fifo_full;
  logic            fifo_empty;
  logic            rr_found;
  logic [IdW-1:0]  rr_sel;
  logic [IdW-1:0]  sel;
  logic            sel_valid;
  logic            host_req;
  logic            push;
  logic            pop;
  int unsigned     scan_idx;

  assign fifo_full  = (count_q == CntW'(MaxOutstanding));
  assign fifo_empty = (count_q == '0);

  // Round-robin scan starting at the current highest-priority requester
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    scan_idx = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      scan_idx = int'(prio_q) + i;
      if (scan_idx >= NumReq) scan_idx = scan_idx - NumReq;
      if (!rr_found && req_i[scan_idx[IdW-1:0]]) begin
        rr_found = 1'b1;
        rr_sel   = scan_idx[IdW-1:0];
      end
    end
  end

  // A pending-but-ungranted request pins the selection until it is accepted
  assign sel       = lock_q ? lock_id_q : rr_sel;
  assign sel_valid = lock_q | rr_found;
  // Full blocks new requests even if a response frees a slot this cycle
  assign host_req  = rst_ni & sel_valid & ~fifo_full;
  assign push      = host_req & host_gnt_i;
  assign pop       = rst_ni & host_r_valid_i & ~fifo_empty;

  // Downstream request mux, zeroed while no request is presented
  always_comb begin
    host_req_o   = host_req;
    host_we_o    = 1'b0;
    host_add_o   = '0;
    host_wdata_o = '0;
    host_be_o    = '0;
    if (host_req) begin
      host_we_o    = we_i[sel];
      host_add_o   = addr_arr[sel];
      host_wdata_o = wdata_arr[sel];
      host_be_o    = be_arr[sel];
    end
  end

  // Grant and response routing, combinational in the same cycle
  always_comb begin
    gnt_o          = '0;
    r_valid_o      = '0;
    r_rdata_o      = '0;
    spurious_rsp_o = rst_ni & host_r_valid_i & fifo_empty;
    if (push) gnt_o[sel] = 1'b1;
    if (pop) begin
      r_valid_o[id_mem_q[rptr_q]] = 1'b1;
      r_rdata_o                   = host_r_rdata_i;
    end
  end

  // Next priority / lock: rotate past the winner on transfer, lock on stall
  always_comb begin
    prio_d    = prio_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (push) begin
      prio_d = (sel == IdW'(NumReq - 1)) ? '0 : sel + IdW'(1);
      lock_d = 1'b0;
    end else if (host_req) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
  end

  // FIFO pointer and occupancy update; push and pop may coincide
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + PtrW'(1);
    if (pop)  rptr_d = (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
  end

  // Control registers; reset discards all outstanding tracking
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q    <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
    end
  end

  // ID storage; contents are meaningless while the count says empty
  always_ff @(posedge clk_i) begin
    if (push) id_mem_q[wptr_q] <= sel;
  end

`ifndef SYNTHESIS
  logic                chk_we_q;
  logic [BusWidth-1:0] chk_addr_q;
  logic [BusWidth-1:0] chk_wdata_q;
  logic [BeW-1:0]      chk_be_q;

  // Snapshot the locked requester's fields when the lock is taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_we_q    <= 1'b0;
      chk_addr_q  <= '0;
      chk_wdata_q <= '0;
      chk_be_q    <= '0;
    end else if (host_req && !host_gnt_i && !lock_q) begin
      chk_we_q    <= we_i[sel];
      chk_addr_q  <= addr_arr[sel];
      chk_wdata_q <= wdata_arr[sel];
      chk_be_q    <= be_arr[sel];
    end
  end

  // Protocol checks: stable locked request, no overflow, sane sizing
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (NumReq >= 2);
      assert (!(push && fifo_full));
      if (lock_q) begin
        assert (req_i[lock_id_q]);
        assert (we_i[lock_id_q] == chk_we_q);
        assert (addr_arr[lock_id_q] == chk_addr_q);
        assert (wdata_arr[lock_id_q] == chk_wdata_q);
        assert (be_arr[lock_id_q] == chk_be_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_host_arb.sv
// Testbench for dm_host_arb: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_dm_host_arb;
  localparam int N   = 2;
  localparam int BW  = 32;
  localparam int MO  = 4;
  localparam int BEW = BW / 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_i = '0;
  logic [N-1:0]    we_i = '0;
  logic [N*BW-1:0] addr_i = '0;
  logic [N*BW-1:0] wdata_i = '0;
  logic [N*BEW-1:0] be_i = '0;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    r_valid_o;
  logic [BW-1:0]   r_rdata_o;
  logic            host_req_o;
  logic            host_we_o;
  logic [BW-1:0]   host_add_o;
  logic [BW-1:0]   host_wdata_o;
  logic [BEW-1:0]  host_be_o;
  logic            host_gnt_i = 1'b0;
  logic            host_r_valid_i = 1'b0;
  logic [BW-1:0]   host_r_rdata_i = '0;
  logic            spurious_rsp_o;

  dm_host_arb #(.NumReq(N), .BusWidth(BW), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
    .host_req_o(host_req_o), .host_we_o(host_we_o), .host_add_o(host_add_o),
    .host_wdata_o(host_wdata_o), .host_be_o(host_be_o),
    .host_gnt_i(host_gnt_i), .host_r_valid_i(host_r_valid_i),
    .host_r_rdata_i(host_r_rdata_i), .spurious_rsp_o(spurious_rsp_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of requester IDs in grant order
  int     mq[$];
  int     m_prio = 0;
  bit     m_lock = 0;
  int     m_lock_id = 0;
  logic [N-1:0] last_gnt = '0;

  function automatic void model_eval(output bit hreq, output int sel,
                                     output logic [N-1:0] gnt, output logic [N-1:0] rv,
                                     output bit spur, output bit pop);
    bit any = 0;
    sel = 0;
    if (m_lock) begin
      any = 1;
      sel = m_lock_id;
    end else begin
      for (int i = 0; i < N; i++) begin
        int k = (m_prio + i) % N;
        if (!any && req_i[k]) begin
          any = 1;
          sel = k;
        end
      end
    end
    hreq = rst_n && any && (mq.size() < MO);
    gnt  = (hreq && host_gnt_i) ? N'(1 << sel) : '0;
    pop  = rst_n && host_r_valid_i && (mq.size() > 0);
    rv   = pop ? N'(1 << mq[0]) : '0;
    spur = rst_n && host_r_valid_i && (mq.size() == 0);
  endfunction

  // Model state advance at each clock edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_prio = 0;
      m_lock = 0;
      m_lock_id = 0;
    end else begin
      bit hreq, spur, pop;
      int sel;
      logic [N-1:0] gnt, rv;
      model_eval(hreq, sel, gnt, rv, spur, pop);
      if (pop) void'(mq.pop_front());
      if (hreq && host_gnt_i) begin
        mq.push_back(sel);
        m_prio = (sel + 1) % N;
        m_lock = 0;
      end else if (hreq) begin
        m_lock = 1;
        m_lock_id = sel;
      end
    end
  end

  // Compare process: every output against the model, mid-cycle
  always @(negedge clk) begin
    bit hreq, spur, pop;
    int sel;
    logic [N-1:0] gnt, rv;
    model_eval(hreq, sel, gnt, rv, spur, pop);
    chk("host_req", host_req_o, hreq);
    chk("gnt", gnt_o, gnt);
    chk("r_valid", r_valid_o, rv);
    chk("spurious", spurious_rsp_o, spur);
    chk("host_we", host_we_o, hreq ? we_i[sel] : 1'b0);
    chk("host_add", host_add_o, hreq ? addr_i[sel*BW +: BW] : '0);
    chk("host_wdata", host_wdata_o, hreq ? wdata_i[sel*BW +: BW] : '0);
    chk("host_be", host_be_o, hreq ? be_i[sel*BEW +: BEW] : '0);
    if (rv != '0) chk("r_rdata", r_rdata_o, host_r_rdata_i);
    last_gnt = gnt;
  end

  task automatic set_req(int k, bit r, bit we, logic [BW-1:0] a, logic [BW-1:0] wd, logic [BEW-1:0] be);
    req_i[k] = r;
    we_i[k] = we;
    addr_i[k*BW +: BW] = a;
    wdata_i[k*BW +: BW] = wd;
    be_i[k*BEW +: BEW] = be;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(bit v, logic [BW-1:0] d);
    host_r_valid_i = v;
    host_r_rdata_i = d;
  endtask

  bit [N-1:0] pend = '0;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #4;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_host_req", host_req_o, 0);
    chk("rst_r_valid", r_valid_o, 0);
    chk("rst_spurious", spurious_rsp_o, 0);
    chk("rst_host_add", host_add_o, 0);
    tick();
    rst_n = 1'b1;

    // Single requester 0 read, granted the same cycle
    set_req(0, 1, 0, 32'h1A11_0000, 0, 4'hF);
    host_gnt_i = 1;
    #3;
    chk("t1_gnt", gnt_o, 2'b01);
    chk("t1_addr", host_add_o, 32'h1A11_0000);
    tick();
    req_i = '0; host_gnt_i = 0;
    tick();
    rsp(1, 32'hDEAD_BEEF);
    #3;
    chk("t1_rvalid", r_valid_o, 2'b01);
    chk("t1_rdata", r_rdata_o, 32'hDEAD_BEEF);
    tick();
    rsp(1, 32'h1234_5678);
    #3;
    chk("t1_empty_spur", spurious_rsp_o, 1);
    chk("t1_empty_rv", r_valid_o, 0);
    tick();
    rsp(0, 0);

    // Lock: requester 0 stalls, requester 1 arrives with higher priority
    set_req(0, 1, 1, 32'h0000_1000, 32'hAAAA_0000, 4'h3);
    #3;
    chk("lk0_add", host_add_o, 32'h0000_1000);
    chk("lk0_gnt", gnt_o, 0);
    tick();
    set_req(1, 1, 0, 32'h0000_2000, 0, 4'hF);
    #3;
    chk("lk1_add", host_add_o, 32'h0000_1000);
    tick();
    #3;
    chk("lk2_add", host_add_o, 32'h0000_1000);
    tick();
    host_gnt_i = 1;
    #3;
    chk("lk3_gnt", gnt_o, 2'b01);
    chk("lk3_add", host_add_o, 32'h0000_1000);
    tick();
    req_i[0] = 0;
    #3;
    chk("lk4_gnt", gnt_o, 2'b10);
    chk("lk4_add", host_add_o, 32'h0000_2000);
    tick();
    req_i = '0; host_gnt_i = 0;
    rsp(1, 32'hA);
    #3;
    chk("lk_rsp0", r_valid_o, 2'b01);
    tick();
    rsp(1, 32'hB);
    #3;
    chk("lk_rsp1", r_valid_o, 2'b10);
    tick();
    rsp(0, 0);

    // Contention until full, then push/pop interplay
    set_req(0, 1, 0, 32'h100, 0, 4'hF);
    set_req(1, 1, 0, 32'h200, 0, 4'hF);
    host_gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("rr_gnt", gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    #3;
    chk("full_host_req", host_req_o, 0);
    chk("full_gnt", gnt_o, 0);
    tick();
    rsp(1, 32'h1);
    #3;
    chk("full_rsp0", r_valid_o, 2'b01);
    chk("full_same_cycle", host_req_o, 0);
    tick();
    rsp(1, 32'h2);
    #3;
    chk("full_rsp1", r_valid_o, 2'b10);
    chk("full_next_cycle", host_req_o, 1);
    chk("full_regnt", gnt_o, 2'b01);
    tick();
    req_i = '0; host_gnt_i = 0;
    rsp(1, 32'h3);
    #3;
    chk("c_rsp2", r_valid_o, 2'b01);
    tick();
    set_req(1, 1, 0, 32'h300, 0, 4'hF);
    host_gnt_i = 1;
    rsp(1, 32'h4);
    #3;
    chk("pp_rsp", r_valid_o, 2'b10);
    chk("pp_gnt", gnt_o, 2'b10);
    tick();
    req_i = '0; host_gnt_i = 0;
    rsp(1, 32'h5);
    #3;
    chk("pp_after0", r_valid_o, 2'b01);
    tick();
    rsp(1, 32'h6);
    #3;
    chk("pp_after1", r_valid_o, 2'b10);
    tick();
    rsp(1, 32'h7);
    #3;
    chk("pp_drained", spurious_rsp_o, 1);
    tick();
    rsp(0, 0);

    // Reset with 3 outstanding
    set_req(0, 1, 0, 32'h400, 0, 4'hF);
    host_gnt_i = 1;
    repeat (3) begin
      #3;
      chk("pre_rst_gnt", gnt_o, 2'b01);
      tick();
    end
    req_i = '0; host_gnt_i = 0;
    rst_n = 0;
    #3;
    chk("mid_rst_host_req", host_req_o, 0);
    chk("mid_rst_rvalid", r_valid_o, 0);
    chk("mid_rst_spur", spurious_rsp_o, 0);
    tick();
    rst_n = 1;
    rsp(1, 32'h8);
    #3;
    chk("post_rst_spur", spurious_rsp_o, 1);
    chk("post_rst_rvalid", r_valid_o, 0);
    tick();
    rsp(0, 0);
    set_req(0, 1, 0, 32'h500, 0, 4'hF);
    set_req(1, 1, 0, 32'h600, 0, 4'hF);
    host_gnt_i = 1;
    #3;
    chk("post_rst_prio", gnt_o, 2'b01);
    tick();
    req_i = '0; host_gnt_i = 0;
    tick();

    // Randomized traffic obeying the hold-until-grant protocol
    pend = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (pend[k] && last_gnt[k]) pend[k] = 0;
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1;
          set_req(k, 1, 1'($urandom_range(0, 1)), $urandom, $urandom, BEW'($urandom));
        end
        req_i[k] = pend[k];
      end
      host_gnt_i = ($urandom_range(0, 3) != 0);
      host_r_valid_i = (mq.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      host_r_rdata_i = $urandom;
      tick();
    end
    req_i = '0; host_gnt_i = 0; rsp(0, 0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
